// File: rtl/cag_rf_pkg.sv
// Shared definitions for the cag register-file responder: register map and enums.
package cag_rf_pkg;

    localparam int unsigned ADDR_CTRL    = 0;
    localparam int unsigned ADDR_STATUS  = 1;
    localparam int unsigned ADDR_EVCNT   = 2;
    localparam int unsigned ADDR_SCRATCH = 3;
    localparam int unsigned ADDR_OVR     = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {RD, WR, BAD} access_t;

endpackage

// File: rtl/cag_rf_sat_counter.sv
// Saturating event counter; a coincident increment and clear leaves the count at 1.
module cag_rf_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (i_clr) begin
                r_count <= WIDTH'(1);
            end else if (r_count != {WIDTH{1'b1}}) begin
                r_count <= r_count + WIDTH'(1);
            end
        end else if (i_clr) begin
            r_count <= '0;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cag_rf_responder.sv
// Register-file responder: latches one access, decodes it in ACCESS, pulses completion in DONE.
module cag_rf_responder
    import cag_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  access_complete,
    output logic                  invalid_address,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] ctrl_o,
    input  logic [DATA_WIDTH-1:0] status_i,
    input  logic                  event_i,
    output logic                  overrun_o
);

    state_t                r_state;
    state_t                w_state_nxt;
    access_t               r_type;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_inv;
    logic                  r_complete;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_ctrl;
    logic [DATA_WIDTH-1:0] r_scratch;
    logic                  r_ovr;
    logic [CNT_WIDTH-1:0]  w_count;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_ovr_set;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_inv_nxt;
    logic                  w_wr_ctrl;
    logic                  w_wr_scratch;
    logic                  w_ovr_clr;
    logic                  w_cnt_clr;

    cag_rf_sat_counter #(.WIDTH(CNT_WIDTH)) u_evcnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (event_i),
        .i_clr   (w_cnt_clr),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    assign w_req = read_en | write_en;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Decode of the latched access; only acts while in ACCESS.
    always_comb begin
        w_accept     = (r_state == IDLE) && w_req;
        w_ovr_set    = (r_state != IDLE) && w_req;
        w_rdata_nxt  = '0;
        w_inv_nxt    = 1'b0;
        w_wr_ctrl    = 1'b0;
        w_wr_scratch = 1'b0;
        w_ovr_clr    = 1'b0;
        w_cnt_clr    = 1'b0;
        if (r_state == ACCESS) begin
            case (r_type)
                RD: begin
                    case (r_addr)
                        ADDR_WIDTH'(ADDR_CTRL):    w_rdata_nxt = r_ctrl;
                        ADDR_WIDTH'(ADDR_STATUS):  w_rdata_nxt = status_i;
                        ADDR_WIDTH'(ADDR_EVCNT): begin
                            w_rdata_nxt = DATA_WIDTH'(w_count);
                            w_cnt_clr   = 1'b1;
                        end
                        ADDR_WIDTH'(ADDR_SCRATCH): w_rdata_nxt = r_scratch;
                        ADDR_WIDTH'(ADDR_OVR):     w_rdata_nxt = DATA_WIDTH'(r_ovr);
                        default:                   w_inv_nxt   = 1'b1;
                    endcase
                end
                WR: begin
                    case (r_addr)
                        ADDR_WIDTH'(ADDR_CTRL):    w_wr_ctrl    = 1'b1;
                        ADDR_WIDTH'(ADDR_SCRATCH): w_wr_scratch = 1'b1;
                        ADDR_WIDTH'(ADDR_OVR):     w_ovr_clr    = r_wdata[0];
                        default:                   w_inv_nxt    = 1'b1;
                    endcase
                end
                default: w_inv_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_type     <= RD;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_inv      <= 1'b0;
            r_complete <= 1'b0;
            r_busy     <= 1'b0;
            r_ctrl     <= '0;
            r_scratch  <= '0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= address;
                r_wdata <= write_data;
                r_type  <= (read_en && write_en) ? BAD : (read_en ? RD : WR);
            end
            if (r_state == ACCESS) begin
                r_rdata <= w_rdata_nxt;
                r_inv   <= w_inv_nxt;
            end
            if (w_wr_ctrl)    r_ctrl    <= r_wdata;
            if (w_wr_scratch) r_scratch <= r_wdata;
            // A new overrun beats a same-cycle clear.
            if (w_ovr_set)      r_ovr <= 1'b1;
            else if (w_ovr_clr) r_ovr <= 1'b0;
            r_complete <= (w_state_nxt == DONE);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign read_data       = r_rdata;
    assign access_complete = r_complete;
    assign invalid_address = r_inv;
    assign busy            = r_busy;
    assign ctrl_o          = r_ctrl;
    assign overrun_o       = r_ovr;

endmodule

// File: tb/tb_cag_rf_responder.sv
// Directed bench for cag_rf_responder; a second instance with a 4-bit counter checks saturation.
module tb_cag_rf_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  address;
    logic        read_en;
    logic        write_en;
    logic [63:0] write_data;
    logic [63:0] status_i;
    logic        event_i;

    logic [63:0] read_data, ctrl_o;
    logic        access_complete, invalid_address, busy, overrun_o;
    logic [63:0] read_data4, ctrl_o4;
    logic        access_complete4, invalid_address4, busy4, overrun_o4;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] g_ctrl_done;
    logic [63:0] g_rd4;

    always #5 clk = ~clk;

    cag_rf_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .address(address), .read_en(read_en), .write_en(write_en),
        .write_data(write_data), .read_data(read_data), .access_complete(access_complete),
        .invalid_address(invalid_address), .busy(busy), .ctrl_o(ctrl_o), .status_i(status_i),
        .event_i(event_i), .overrun_o(overrun_o)
    );

    cag_rf_responder #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .address(address), .read_en(read_en), .write_en(write_en),
        .write_data(write_data), .read_data(read_data4), .access_complete(access_complete4),
        .invalid_address(invalid_address4), .busy(busy4), .ctrl_o(ctrl_o4), .status_i(status_i),
        .event_i(event_i), .overrun_o(overrun_o4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access issued in the current cycle N; checks the N+1..N+3 response.
    task automatic acc(input string tag, input logic rd, input logic wr, input logic [3:0] a,
                       input logic [63:0] d, input logic ev, input logic [63:0] exp_rd,
                       input logic exp_inv);
        address = a; read_en = rd; write_en = wr; write_data = d;
        tick();
        read_en = 1'b0; write_en = 1'b0; event_i = ev;
        chk({tag, " busy@N+1"}, 64'(busy), 64'd1);
        chk({tag, " cmpl@N+1"}, 64'(access_complete), 64'd0);
        tick();
        event_i = 1'b0;
        chk({tag, " cmpl@N+2"}, 64'(access_complete), 64'd1);
        chk({tag, " rdata@N+2"}, read_data, exp_rd);
        chk({tag, " inv@N+2"}, 64'(invalid_address), 64'(exp_inv));
        g_ctrl_done = ctrl_o;
        g_rd4       = read_data4;
        tick();
        chk({tag, " cmpl@N+3"}, 64'(access_complete), 64'd0);
        chk({tag, " busy@N+3"}, 64'(busy), 64'd0);
        chk({tag, " rdata hold"}, read_data, exp_rd);
        chk({tag, " inv hold"}, 64'(invalid_address), 64'(exp_inv));
    endtask

    initial begin
        rst = 1'b1; address = '0; read_en = 1'b0; write_en = 1'b0;
        write_data = '0; status_i = 64'hA5A5_0000_1234_5A5A; event_i = 1'b0;
        repeat (3) tick();
        chk("rst rdata", read_data, 64'd0);
        chk("rst cmpl", 64'(access_complete), 64'd0);
        chk("rst inv", 64'(invalid_address), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst ctrl", ctrl_o, 64'd0);
        chk("rst ovr", 64'(overrun_o), 64'd0);
        rst = 1'b0;
        tick();

        // Basic register writes and reads
        acc("wr ctrl", 1'b0, 1'b1, 4'h0, 64'hDEAD_BEEF, 1'b0, 64'd0, 1'b0);
        chk("ctrl@N+2", g_ctrl_done, 64'hDEAD_BEEF);
        acc("rd ctrl", 1'b1, 1'b0, 4'h0, 64'd0, 1'b0, 64'hDEAD_BEEF, 1'b0);
        acc("wr scr", 1'b0, 1'b1, 4'h3, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b0);
        acc("rd scr", 1'b1, 1'b0, 4'h3, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
        acc("rd status", 1'b1, 1'b0, 4'h1, 64'd0, 1'b0, 64'hA5A5_0000_1234_5A5A, 1'b0);

        // Event counter: saturation on the 4-bit instance, read-to-clear
        event_i = 1'b1;
        repeat (20) @(posedge clk);
        #1 event_i = 1'b0;
        acc("rd evcnt20", 1'b1, 1'b0, 4'h2, 64'd0, 1'b0, 64'd20, 1'b0);
        chk("evcnt sat4", g_rd4, 64'd15);
        acc("rd evcnt clr", 1'b1, 1'b0, 4'h2, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("evcnt clr4", g_rd4, 64'd0);
        event_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 event_i = 1'b0;
        acc("rd evcnt5", 1'b1, 1'b0, 4'h2, 64'd0, 1'b0, 64'd5, 1'b0);
        acc("rd evcnt ev", 1'b1, 1'b0, 4'h2, 64'd0, 1'b1, 64'd0, 1'b0);
        acc("rd evcnt 1", 1'b1, 1'b0, 4'h2, 64'd0, 1'b0, 64'd1, 1'b0);

        // Invalid accesses leave registers untouched
        acc("rd 0x9", 1'b1, 1'b0, 4'h9, 64'd0, 1'b0, 64'd0, 1'b1);
        acc("wr status", 1'b0, 1'b1, 4'h1, 64'hFFFF, 1'b0, 64'd0, 1'b1);
        acc("wr evcnt", 1'b0, 1'b1, 4'h2, 64'hFFFF, 1'b0, 64'd0, 1'b1);
        acc("wr 0x9", 1'b0, 1'b1, 4'h9, 64'h1111, 1'b0, 64'd0, 1'b1);
        acc("rd+wr ctrl", 1'b1, 1'b1, 4'h0, 64'd0, 1'b0, 64'd0, 1'b1);
        chk("ctrl kept", ctrl_o, 64'hDEAD_BEEF);
        acc("rd scr kept", 1'b1, 1'b0, 4'h3, 64'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);

        // Overrun: request during ACCESS is ignored and sticky-flagged
        address = 4'h0; write_en = 1'b1; write_data = 64'h55;
        tick();
        write_en = 1'b0; read_en = 1'b1; address = 4'h3;
        chk("ovr N+1", 64'(overrun_o), 64'd0);
        tick();
        read_en = 1'b0;
        chk("ovr cmpl", 64'(access_complete), 64'd1);
        chk("ovr ctrl", ctrl_o, 64'h55);
        chk("ovr set", 64'(overrun_o), 64'd1);
        tick();
        chk("ovr N+3 cmpl", 64'(access_complete), 64'd0);
        tick();
        chk("ovr no 2nd cmpl", 64'(access_complete), 64'd0);
        acc("rd ovr1", 1'b1, 1'b0, 4'h4, 64'd0, 1'b0, 64'd1, 1'b0);
        acc("wr ovr0", 1'b0, 1'b1, 4'h4, 64'd0, 1'b0, 64'd0, 1'b0);
        chk("ovr kept", 64'(overrun_o), 64'd1);
        acc("wr ovr1", 1'b0, 1'b1, 4'h4, 64'd1, 1'b0, 64'd0, 1'b0);
        chk("ovr cleared", 64'(overrun_o), 64'd0);
        acc("rd ovr0", 1'b1, 1'b0, 4'h4, 64'd0, 1'b0, 64'd0, 1'b0);

        // Reset in the middle of a write aborts it
        address = 4'h0; write_en = 1'b1; write_data = 64'h1234;
        tick();
        write_en = 1'b0; rst = 1'b1;
        tick();
        chk("abort cmpl", 64'(access_complete), 64'd0);
        chk("abort ctrl", ctrl_o, 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();
        chk("abort no cmpl", 64'(access_complete), 64'd0);
        acc("post-rst wr", 1'b0, 1'b1, 4'h3, 64'd7, 1'b0, 64'd0, 1'b0);
        acc("post-rst rd", 1'b1, 1'b0, 4'h3, 64'd0, 1'b0, 64'd7, 1'b0);
        acc("post-rst ctrl", 1'b1, 1'b0, 4'h0, 64'd0, 1'b0, 64'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
